// File: rtl/mpsoc_sys_info.sv
// mpsoc_sys_info: system-information Avalon-MM slave with a registered 1-cycle read path.
// Provides ID, timestamp, CPU info, a 64-bit uptime counter with a coherent high-word shadow,
// a scratch register and per-CPU boot-release bits.
// Optional macro MPSOC_SYS_INFO_UPTIME_EN builds the uptime counter and its shadow. Without
// it, words 3/4 read zero and INFO bit 23 reads 0.
module mpsoc_sys_info #(
  parameter logic [31:0] SYSTEM_ID = 32'h00000001,
  parameter logic [31:0] TIMESTAMP = 32'h00000000,
  parameter int unsigned NUM_CPUS  = 4,
  parameter logic [7:0]  VERSION   = 8'h02,
  parameter logic [31:0] BOOT_MASK = 32'h00000001
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [2:0]          address,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic                readdatavalid,
  output logic [NUM_CPUS-1:0] cpu_release
);

  logic                rd_acc;
  logic                wr_acc;
  logic [31:0]         scratch;
  logic [NUM_CPUS-1:0] rel;
  logic [31:0]         rel_word;
  logic [31:0]         uptime_lo;
  logic [31:0]         uptime_hi;
  logic                uptime_present;
  logic [31:0]         info;
  logic [31:0]         rd_mux;

  // A simultaneous read wins; the write is dropped.
  assign rd_acc = chipselect & read;
  assign wr_acc = chipselect & write & ~read;

`ifdef MPSOC_SYS_INFO_UPTIME_EN
  logic [63:0] uptime;
  logic [31:0] shadow;

  // Free-running counter; a low-word read captures the matching high word into the shadow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      uptime <= 64'h0;
      shadow <= 32'h0;
    end else begin
      uptime <= uptime + 64'd1;
      if (rd_acc && (address == 3'd3)) begin
        shadow <= uptime[63:32];
      end
    end
  end

  assign uptime_lo      = uptime[31:0];
  assign uptime_hi      = shadow;
  assign uptime_present = 1'b1;
`else
  assign uptime_lo      = 32'h0;
  assign uptime_hi      = 32'h0;
  assign uptime_present = 1'b0;
`endif

  assign info = {VERSION, uptime_present, 7'h00, 16'(NUM_CPUS)};

  // Scratch register: full-word writes only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scratch <= 32'h0;
    end else if (wr_acc && (address == 3'd5)) begin
      scratch <= writedata;
    end
  end

  // Release bits: word 6 sets, word 7 clears; bits above NUM_CPUS are not stored.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rel <= BOOT_MASK[NUM_CPUS-1:0];
    end else if (wr_acc && (address == 3'd6)) begin
      rel <= rel | writedata[NUM_CPUS-1:0];
    end else if (wr_acc && (address == 3'd7)) begin
      rel <= rel & ~writedata[NUM_CPUS-1:0];
    end
  end

  assign cpu_release = rel;

  // Zero-extend the release state to a full word.
  always_comb begin
    rel_word                 = 32'h0;
    rel_word[NUM_CPUS-1:0]   = rel;
  end

  // Read-data selection by word address.
  always_comb begin
    rd_mux = 32'h0;
    case (address)
      3'd0: rd_mux = SYSTEM_ID;
      3'd1: rd_mux = TIMESTAMP;
      3'd2: rd_mux = info;
      3'd3: rd_mux = uptime_lo;
      3'd4: rd_mux = uptime_hi;
      3'd5: rd_mux = scratch;
      3'd6: rd_mux = rel_word;
      3'd7: rd_mux = rel_word;
      default: rd_mux = 32'h0;
    endcase
  end

  // Registered read port: data holds between reads, valid pulses one cycle per accepted read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      readdata      <= 32'h0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= rd_acc;
      if (rd_acc) begin
        readdata <= rd_mux;
      end
    end
  end

endmodule
